// File: rtl/systolic_result_drain.sv
// ============================================================================
// systolic_result_drain
// Snapshots the PE grid results on a capture strobe and streams them out in
// row-major order over a valid/ready interface.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_result_drain #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 5,
  localparam int IDX_W    = (N_SIZE > 1) ? $clog2(N_SIZE) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  capture,
  input  logic [N_SIZE*N_SIZE*2*DATAWIDTH-1:0]  c_in,
  output logic [2*DATAWIDTH-1:0]                out_data,
  output logic [IDX_W-1:0]                      out_row,
  output logic [IDX_W-1:0]                      out_col,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_last,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int EW = 2 * DATAWIDTH;
  localparam int NE = N_SIZE * N_SIZE;
  localparam int AW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_SIZE - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic             overrun_q, overrun_d;
  logic [EW-1:0]    mem_q [NE];
  logic [EW-1:0]    mem_d [NE];

  logic             draining;
  logic             at_last;
  logic             handshake;
  logic             load;
  logic [AW-1:0]    elem_idx;

  assign draining  = (state_q == S_DRAIN);
  assign at_last   = (row_q == IDX_MAX) && (col_q == IDX_MAX);
  assign handshake = draining && out_ready;
  assign elem_idx  = AW'(row_q) * AW'(N_SIZE) + AW'(col_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    overrun_d = 1'b0;
    load      = 1'b0;
    mem_d     = mem_q;

    case (state_q)
      S_IDLE: begin
        if (capture) begin
          load    = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (handshake) begin
          if (at_last) begin
            row_d = '0;
            col_d = '0;
            // A capture landing on the final handshake chains straight into the next matrix.
            if (capture) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (col_q == IDX_MAX) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        if (capture && !(handshake && at_last)) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      for (int k = 0; k < NE; k++) begin
        mem_d[k] = c_in[k*EW +: EW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NE; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      overrun_q <= overrun_d;
      for (int k = 0; k < NE; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  assign out_valid = draining;
  assign busy      = draining;
  assign out_last  = draining && at_last;
  assign out_row   = draining ? row_q : '0;
  assign out_col   = draining ? col_q : '0;
  assign out_data  = draining ? mem_q[elem_idx] : '0;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire
